// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the 50 MHz packer and 2 MHz reader
package ctrl_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } pk_state_e;

    typedef enum logic {
        NO_WR = 1'b0,
        WR    = 1'b1
    } wr_state_e;

endpackage

// File: rtl/shift_reg_sipo.sv
// rtl/shift_reg_sipo.sv - serial-in/parallel-out shift register with enable
module shift_reg_sipo #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] data_next_o
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    // Next value includes the bit being sampled this cycle, so the owner can
    // capture a completed byte on the same edge that shifts its last bit in.
    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[DATA_W-2:0], bit_i};
            end else begin
                sr_d = {bit_i, sr_q[DATA_W-1:1]};
            end
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign data_o      = sr_q;
    assign data_next_o = sr_d;

endmodule

// File: rtl/ctrl_50mhz_packer.sv
// rtl/ctrl_50mhz_packer.sv - deserializes a gated bit stream into bytes and writes them to the CDC FIFO
module ctrl_50mhz_packer
    import ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_ena,
    input  logic              serial_data,
    input  logic              full,
    input  logic              clr_overrun,
    output logic              wr,
    output logic [DATA_W-1:0] wr_data,
    output logic              overrun
);

    localparam int              CNT_W   = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    pk_state_e         state_q, state_d;
    wr_state_e         wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] sr_data;
    logic [DATA_W-1:0] sr_next;
    logic              complete;

    shift_reg_sipo #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (data_ena),
        .bit_i       (serial_data),
        .data_o      (sr_data),
        .data_next_o (sr_next)
    );

    // The register contents are only consumed through the next-value port.
    logic unused_sr;
    assign unused_sr = ^sr_data;

    assign complete = data_ena && (cnt_q == CNT_MAX);

    // Next-state: bit counter, framing FSM, write pending and sticky overrun.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = NO_WR;
        wr_data_d = wr_data_q;
        overrun_d = overrun_q;

        // Any gap in data_ena drops the partial byte so the next packet is aligned.
        if (!data_ena || complete) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE:    if (data_ena && !complete) state_d = SHIFT;
            SHIFT:   if (!data_ena || complete) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // wr_data is refreshed even for a dropped byte; only the strobe is withheld.
        if (complete) begin
            wr_data_d = sr_next;
            if (!full) begin
                wr_d = WR;
            end
        end

        // A new drop beats a clear arriving in the same cycle.
        if (complete && full) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= NO_WR;
            wr_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            wr_data_q <= wr_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr      = (wr_q == WR);
    assign wr_data = wr_data_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_ctrl_50mhz_packer.sv
// tb/tb_ctrl_50mhz_packer.sv - scoreboard bench for ctrl_50mhz_packer, MSB-first and LSB-first builds
module tb_ctrl_50mhz_packer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       data_ena;
    logic       serial_data;
    logic       full;
    logic       clr_overrun;

    logic       wr0, wr1;
    logic [7:0] wrd0, wrd1;
    logic       ov0, ov1;

    int checks = 0;
    int passed = 0;
    bit mon_en = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #10 clk = ~clk;

    ctrl_50mhz_packer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_ena    (data_ena),
        .serial_data (serial_data),
        .full        (full),
        .clr_overrun (clr_overrun),
        .wr          (wr0),
        .wr_data     (wrd0),
        .overrun     (ov0)
    );

    ctrl_50mhz_packer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk         (clk),
        .reset_n     (reset_n),
        .data_ena    (data_ena),
        .serial_data (serial_data),
        .full        (full),
        .clr_overrun (clr_overrun),
        .wr          (wr1),
        .wr_data     (wrd1),
        .overrun     (ov1)
    );

    function automatic logic [7:0] bitrev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: every wr pulse must match the oldest expected byte.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr0 === 1'b1) begin
                check("msb_wr_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) check("msb_wr_data", 32'(wrd0), 32'(q0.pop_front()));
            end
            if (wr1 === 1'b1) begin
                check("lsb_wr_expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) check("lsb_wr_data", 32'(wrd1), 32'(q1.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            data_ena = 1'b0; serial_data = 1'b0; full = 1'b0; clr_overrun = 1'b0; reset_n = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    // Sends v MSB-first on the wire; optional full / clr / reset on the last bit.
    task automatic send_byte(input logic [7:0] v, input logic f, input logic clr, input logic rst_last);
        for (int i = 7; i >= 0; i--) begin
            data_ena    = 1'b1;
            serial_data = v[i];
            full        = (i == 0) ? f : 1'b0;
            clr_overrun = (i == 0) ? clr : 1'b0;
            reset_n     = (i == 0) ? !rst_last : 1'b1;
            if (i == 0 && !f && !rst_last) begin
                q0.push_back(v);
                q1.push_back(bitrev(v));
            end
            @(posedge clk); #1;
            if (i == 7) begin
                check("wr_low_first_bit_msb", 32'(wr0), 32'd0);
                check("wr_low_first_bit_lsb", 32'(wr1), 32'd0);
            end
        end
        full = 1'b0; clr_overrun = 1'b0; reset_n = 1'b1;
        check("wr_after_last_bit_msb", 32'(wr0), 32'(!f && !rst_last));
        check("wr_after_last_bit_lsb", 32'(wr1), 32'(!f && !rst_last));
    endtask

    logic [7:0] tmp;

    initial begin
        reset_n = 1'b0; data_ena = 1'b0; serial_data = 1'b0; full = 1'b0; clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr",      32'(wr0),  32'd0);
        check("reset_wr_data", 32'(wrd0), 32'd0);
        check("reset_overrun", 32'(ov0),  32'd0);
        check("reset_wr_lsb",  32'(wr1),  32'd0);
        check("reset_wrd_lsb", 32'(wrd1), 32'd0);
        mon_en = 1'b1;
        idle(1);

        // Single byte 1,0,1,0,0,1,0,1.
        send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("a5_wr_one_cycle", 32'(wr0), 32'd0);
        check("a5_overrun", 32'(ov0), 32'd0);
        idle(2);

        // Four back-to-back bytes with data_ena held high.
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0, 1'b0);
        send_byte(8'h78, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Five bits, one-cycle gap, then a full byte.
        tmp = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            data_ena = 1'b1; serial_data = tmp[i];
            @(posedge clk); #1;
        end
        idle(1);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Drop with full, clear, then drop coinciding with clear.
        send_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        check("drop_overrun_msb", 32'(ov0), 32'd1);
        check("drop_overrun_lsb", 32'(ov1), 32'd1);
        check("drop_wr_data_upd", 32'(wrd0), 32'hFF);
        idle(2);
        check("overrun_sticky", 32'(ov0), 32'd1);
        clr_overrun = 1'b1; @(posedge clk); #1; clr_overrun = 1'b0;
        check("overrun_cleared", 32'(ov0), 32'd0);
        send_byte(8'h81, 1'b1, 1'b0, 1'b0);
        check("overrun_set_again", 32'(ov0), 32'd1);
        send_byte(8'h42, 1'b1, 1'b1, 1'b0);
        check("set_beats_clear_msb", 32'(ov0), 32'd1);
        check("set_beats_clear_lsb", 32'(ov1), 32'd1);
        check("drop_wr_data_lsb", 32'(wrd1), 32'(bitrev(8'h42)));
        idle(2);

        // Reset at bit 6 of a byte.
        tmp = 8'h99;
        for (int i = 7; i >= 2; i--) begin
            data_ena = 1'b1; serial_data = tmp[i];
            @(posedge clk); #1;
        end
        data_ena = 1'b1; serial_data = tmp[1]; reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst_mid_wr",      32'(wr0),  32'd0);
        check("rst_mid_wr_data", 32'(wrd0), 32'd0);
        check("rst_mid_overrun", 32'(ov0),  32'd0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Reset on the completion edge suppresses the pending write.
        send_byte(8'hE7, 1'b0, 1'b0, 1'b1);
        check("rst_wr_cycle_data", 32'(wrd0), 32'd0);
        send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(1);

        // LSB-first build: this wire order gives 8'h03 there, 8'hC0 here.
        send_byte(8'hC0, 1'b0, 1'b0, 1'b0);
        idle(3);

        check("msb_queue_drained", 32'(q0.size()), 32'd0);
        check("lsb_queue_drained", 32'(q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_50mhz_packer.md
Name: ctrl_50mhz_packer

Overview:
- Upstream neighbour of the 2 MHz FIFO-read/accumulate controller.
- Runs in the 50 MHz domain and deserializes the incoming bit stream (serial_data qualified by data_ena) into bytes.
- Writes each completed byte into the clock-crossing FIFO, respecting FIFO full.
- Reports dropped bytes through a sticky overrun flag.

Parameters:
- DATA_W, 8, width of one FIFO word and bits per assembled byte.
- MSB_FIRST, 1, 1: first received bit lands in wr_data[DATA_W-1]; 0: first received bit lands in wr_data[0].

Ports:
- clk  input  1  50 MHz clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- data_ena  input  1  high while serial_data carries a valid bit this cycle; low between packets.
- serial_data  input  1  serial bit, sampled only when data_ena=1.
- full  input  1  FIFO full flag (50 MHz side).
- wr  output  1  FIFO write strobe, one-cycle pulse.
- wr_data  output  DATA_W  byte presented to FIFO; valid whenever wr=1.
- overrun  output  1  sticky: a completed byte was dropped because full=1.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset: sampled on rising clk while reset_n=0. Forces wr=0, wr_data=0, overrun=0, bit counter=0, shift register=0, FSM=IDLE. Reset mid-byte discards the partial byte; a pending write is not issued.
- Bit counter: 0..DATA_W-1, width clog2(DATA_W).
- Shift register: DATA_W bits.
- Each cycle with data_ena=1:
  - the shift register takes serial_data per MSB_FIRST;
  - the counter increments;
  - on count=DATA_W-1 the counter wraps to 0 and the byte is complete.
- Back-to-back bytes: data_ena may stay high continuously. Byte N+1 bit 0 is accepted in the same cycle wr pulses for byte N; no bubble is required.
- Completion: the completed byte (shift value including the current bit) is copied into the wr_data holding register at that edge. wr=1 in the following cycle, for exactly one cycle. Latency is one cycle from the last bit sample to the wr pulse. wr_data holds its value until the next completion.
- Full handling: full is sampled in the completion cycle.
  - full=0: the write is scheduled as above.
  - full=1: no wr pulse; wr_data is still updated; overrun=1 from the next cycle.
- overrun:
  - clears only on reset or clr_overrun=1.
  - If clr_overrun=1 and a new drop occur in the same cycle, set wins (overrun stays 1).
- data_ena falling mid-byte (counter≠0): the partial byte is discarded and the counter returns to 0 on the next edge. data_ena low for even one cycle aborts the byte, so the next packet starts byte-aligned.
- FSM states:
  - IDLE: counter=0, no partial byte.
  - SHIFT: counter>0.
  - WRITE: wr pulse cycle; may coexist with SHIFT/IDLE bit activity.
  - Transitions:
    - IDLE→SHIFT on data_ena.
    - SHIFT→SHIFT while data_ena and counter<DATA_W-1.
    - SHIFT→IDLE on data_ena=0 (abort) or on wrap.
    - WRITE is a separate 1-bit write-pending register, set on completion with full=0, cleared the following cycle.
- No X on outputs after reset; outputs are registered.

Decomposition:
- Shared package ctrl_pkg:
  - FSM enum (IDLE, SHIFT) with explicit 1-bit encodings;
  - write-pending enum (NO_WR, WR);
  - localparam BYTES_PER_WORD=4, shared with the 2 MHz side;
  - DATA_W default.
- One natural sub-module: shift_reg_sipo (serial-in/parallel-out, enable, MSB_FIRST parameter). The counter, FSM and write/overrun logic stay in ctrl_50mhz_packer.

Test Plan:
- Reset, then data_ena=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 (MSB_FIRST=1), full=0 -> single wr pulse on cycle 9; wr_data=8'hA5; overrun=0.
- 32 consecutive bits, data_ena held high, bytes 8'h12,8'h34,8'h56,8'h78 -> wr pulses on cycles 9,17,25,33; wr_data matches in order; no missed bit at byte boundaries.
- data_ena high for 5 bits then low 1 cycle, then 8 bits of 8'hC3 -> exactly one wr, wr_data=8'hC3; partial byte never written.
- full=1 during completion of byte 8'hFF -> no wr; overrun=1 next cycle. clr_overrun pulse -> overrun=0. Repeat with clr_overrun coinciding with a drop -> overrun remains 1.
- reset_n=0 asserted at bit 6 of a byte and at the wr cycle -> wr=0 at that edge; counter restarts; a subsequent 8'h3C is written correctly.
- MSB_FIRST=0 build, bits 1,0,1,0,0,1,0,1 -> wr_data=8'hA5 reversed (8'hA5 bit-reversed = 8'hA5); also stream 1,1,0,0,0,0,0,0 -> wr_data=8'h03.
